sid_regs: RTL and testbench
===========================

Name: sid_regs

Overview:
- CPU-side register file for the SID core: captures bus writes into the voice, filter and volume registers that feed the three voice instances.
- Returns the read-only registers POTX, POTY, OSC3 and ENV3 to the CPU.
- Emulates open-bus decay of the last written value.
- Contains the paddle (pot) sampling state machine that drives the external discharge line.

Parameters:
- DECAY_CYCLES, 40000, number of ce_1m ticks the last written bus value persists before reading back 0.
- DECAY_W, 16, width of the decay counter; must hold DECAY_CYCLES.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_1m  in  1  1 MHz clock enable, one clock wide
- cs  in  1  chip select, one clock per access
- we  in  1  1=write, 0=read (qualified by cs)
- addr  in  5  register address 0x00-0x1F
- data_in  in  8  write data
- data_out  out  8  registered read data
- voice_regs  out  168  {v3,v2,v1}; per voice {sus_rel,att_dec,control,pw_hi(4b zero-extended),pw_lo,freq_hi,freq_lo}
- fc_lo  out  3  filter cutoff low
- fc_hi  out  8  filter cutoff high
- res_filt  out  8  resonance / routing
- mode_vol  out  8  filter mode / volume
- osc3_in  in  8  voice 3 osc_out
- env3_in  in  8  voice 3 env_out
- pot_x_in  in  1  pot X comparator, asynchronous
- pot_y_in  in  1  pot Y comparator, asynchronous
- pot_dis  out  1  1 = discharge pot capacitors

Behaviour:
- Reset: all writable registers 0, data_out 0, bus latch 0, decay counter 0, POTX/POTY 0, pot FSM in DISCHARGE with phase count 0, pot_dis 1.
- Write (cs & we, any clock):
  - 0x00-0x18 update the mapped register on the next edge; pw_hi stores data_in[3:0].
  - 0x19-0x1F are not stored.
  - Every write loads bus latch = data_in and decay counter = DECAY_CYCLES.
- Read (cs & !we): data_out is valid on the edge after the request and held until the next read. Address map:
  - 0x19 → POTX
  - 0x1A → POTY
  - 0x1B → osc3_in
  - 0x1C → env3_in (sampled at the request edge)
  - all other addresses → bus latch
- Decay: on ce_1m, if counter > 0 it decrements; when it reaches 0 the latch clears to 0. A write on the same cycle as a ce_1m tick wins and reloads the counter.
- Pot FSM (advances on ce_1m only; 9-bit phase counter, 256 ticks per state):
  - DISCHARGE: pot_dis=1; axis counters cleared; done flags cleared; after 256 ticks → CHARGE.
  - CHARGE: pot_dis=0; each axis counter increments per tick until its synchronised comparator is first seen 1, then sets done and freezes; counters saturate at 255.
  - Leaving CHARGE after 256 ticks: POTX/POTY ← counters (255 if never done), then → DISCHARGE.
  - Full period is 512 ticks.
- Comparator inputs pass through a 2-FF synchroniser on clock before use.
- Reset mid-sample discards partial counts; POTX/POTY return to 0 until the first completed CHARGE.
- Register outputs are plain flops, so downstream voices see new values one clock after the write.

Optional Feature:
- Macro SID_POT_EN.
- Defined: pot synchronisers, FSM and counters are built as described above.
- Undefined: no pot logic; POTX and POTY read 0xFF; pot_dis tied to 0; pot_x_in and pot_y_in are ignored.

Decomposition:
- Package sid_pkg holds:
  - register address constants (ADDR_FREQ_LO_V1 … ADDR_ENV3);
  - voice register stride (7);
  - POT_PHASE_TICKS=256;
  - the pot FSM state enum {DISCHARGE, CHARGE}.
- One sub-module, sid_pot_axis, instantiated twice: synchroniser, saturating 8-bit counter, done flag, result register. The phase FSM stays in sid_regs.

Test Plan:
- Write 0x12→0x01, 0x00→0x34, 0x01→0x12 → voice_regs freq_lo=0x34, freq_hi=0x12 for v1; v3 field untouched.
- Write 0x03←0xAB → pw_hi field reads 0x0B.
- Read 0x1B with osc3_in=0x5A and 0x1C with env3_in=0xC3 → data_out=0x5A, then 0xC3, each one clock after cs.
- Write 0x77 to 0x1D, then read 0x00 → 0x77. Run DECAY_CYCLES+1 ce_1m ticks (set DECAY_CYCLES=10 in the bench), then read → 0x00. A write on the final tick reloads the latch.
- SID_POT_EN defined:
  - pot_x_in rises 100 ticks into CHARGE, pot_y_in held 0 → POTX=100±2 (synchroniser latency); POTY=255; pot_dis is high for exactly 256 ticks per 512.
  - Assert reset_n low mid-CHARGE → POTX/POTY=0, pot_dis=1 immediately (asynchronous); next full cycle yields valid values.
- SID_POT_EN undefined: read 0x19 and 0x1A → 0xFF; pot_dis stays 0.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants, types and helpers for the SID CPU-side register block.
// Holds the register address map, voice register layout, pot sampling
// timing and the pot FSM state type.
package sid_pkg;

  // Voice register layout: three voices, seven byte registers each.
  localparam int NUM_VOICES   = 3;
  localparam int VOICE_STRIDE = 7;
  localparam int VOICE_REGS   = NUM_VOICES * VOICE_STRIDE;
  localparam int PW_HI_OFS    = 3;

  // Register address map.
  localparam logic [4:0] ADDR_FREQ_LO_V1 = 5'h00;
  localparam logic [4:0] ADDR_PW_HI_V1   = 5'h03;
  localparam logic [4:0] ADDR_FC_LO      = 5'h15;
  localparam logic [4:0] ADDR_FC_HI      = 5'h16;
  localparam logic [4:0] ADDR_RES_FILT   = 5'h17;
  localparam logic [4:0] ADDR_MODE_VOL   = 5'h18;
  localparam logic [4:0] ADDR_POTX       = 5'h19;
  localparam logic [4:0] ADDR_POTY       = 5'h1A;
  localparam logic [4:0] ADDR_OSC3       = 5'h1B;
  localparam logic [4:0] ADDR_ENV3       = 5'h1C;

  // Pot sampling: ce_1m ticks spent in each FSM state.
  localparam int POT_PHASE_TICKS = 256;

  typedef enum logic {
    DISCHARGE = 1'b0,
    CHARGE    = 1'b1
  } pot_state_e;

  // True for the pulse-width-high register of any voice (only 4 bits stored).
  function automatic logic is_pw_hi(input logic [4:0] a);
    logic hit;
    hit = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (a == 5'(int'(ADDR_PW_HI_V1) + v * VOICE_STRIDE)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/sid_pot_axis.sv
// One paddle axis: 2-FF comparator synchroniser, saturating 8-bit charge
// counter with a done flag, and the result register read back by the CPU.
// Ports: clock_i/reset_ni, clr_i (discharge tick), cnt_en_i (charge tick),
//        latch_i (last tick of the charge phase), comp_i (async), result_o.
module sid_pot_axis
  import sid_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       clr_i,
  input  logic       cnt_en_i,
  input  logic       latch_i,
  input  logic       comp_i,
  output logic [7:0] result_o
);

  logic       sync1_q, sync2_q;
  logic [7:0] cnt_q;
  logic       done_q;
  logic [7:0] result_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= comp_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (cnt_en_i) begin
      // A comparator first seen on the final tick still counts as a hit.
      if (latch_i) result_q <= (done_q || sync2_q) ? cnt_q : 8'hFF;
      if (!done_q) begin
        if (sync2_q)             done_q <= 1'b1;
        else if (cnt_q != 8'hFF) cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/sid_regs.sv
// SID CPU-side register file: write capture for voice/filter/volume regs,
// read-back of POTX/POTY/OSC3/ENV3, open-bus decay latch, pot sampling FSM.
// Ports: clock/reset_n, ce_1m, cs/we/addr/data_in/data_out bus, register
// outputs to voices/filter, osc3_in/env3_in, pot_x_in/pot_y_in, pot_dis.
// Optional: define SID_POT_EN to build the pot sampler; otherwise POTX/POTY
// read 0xFF and pot_dis is held low.
module sid_regs
  import sid_pkg::*;
#(
  parameter int DECAY_CYCLES = 40000,
  parameter int DECAY_W      = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ce_1m,
  input  logic         cs,
  input  logic         we,
  input  logic [4:0]   addr,
  input  logic [7:0]   data_in,
  output logic [7:0]   data_out,
  output logic [167:0] voice_regs,
  output logic [2:0]   fc_lo,
  output logic [7:0]   fc_hi,
  output logic [7:0]   res_filt,
  output logic [7:0]   mode_vol,
  input  logic [7:0]   osc3_in,
  input  logic [7:0]   env3_in,
  input  logic         pot_x_in,
  input  logic         pot_y_in,
  output logic         pot_dis
);

  logic               wr_en, rd_en;
  logic [7:0]         vreg_q [VOICE_REGS];
  logic [2:0]         fc_lo_q;
  logic [7:0]         fc_hi_q, res_filt_q, mode_vol_q;
  logic [7:0]         latch_q, latch_d;
  logic [DECAY_W-1:0] decay_q, decay_d;
  logic [7:0]         data_out_q, data_out_d;
  logic [7:0]         rd_dat;
  logic [7:0]         potx_val, poty_val;

  assign wr_en = cs & we;
  assign rd_en = cs & ~we;

  // Writable registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICE_REGS; i++) vreg_q[i] <= '0;
      fc_lo_q    <= '0;
      fc_hi_q    <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < VOICE_REGS; i++) begin
        if (addr == 5'(i)) vreg_q[i] <= is_pw_hi(addr) ? {4'h0, data_in[3:0]} : data_in;
      end
      case (addr)
        ADDR_FC_LO:    fc_lo_q    <= data_in[2:0];
        ADDR_FC_HI:    fc_hi_q    <= data_in;
        ADDR_RES_FILT: res_filt_q <= data_in;
        ADDR_MODE_VOL: mode_vol_q <= data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < VOICE_REGS; i++) voice_regs[i*8 +: 8] = vreg_q[i];
  end

  assign fc_lo    = fc_lo_q;
  assign fc_hi    = fc_hi_q;
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;

  // Open-bus latch: a write always wins over a same-cycle decay tick.
  always_comb begin
    latch_d = latch_q;
    decay_d = decay_q;
    if (wr_en) begin
      latch_d = data_in;
      decay_d = DECAY_W'(DECAY_CYCLES);
    end else if (ce_1m && (decay_q != '0)) begin
      decay_d = decay_q - 1'b1;
      if (decay_q == DECAY_W'(1)) latch_d = '0;
    end
  end

  // Read mux; data_out holds its value between reads.
  always_comb begin
    case (addr)
      ADDR_POTX: rd_dat = potx_val;
      ADDR_POTY: rd_dat = poty_val;
      ADDR_OSC3: rd_dat = osc3_in;
      ADDR_ENV3: rd_dat = env3_in;
      default:   rd_dat = latch_q;
    endcase
    data_out_d = rd_en ? rd_dat : data_out_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch_q    <= '0;
      decay_q    <= '0;
      data_out_q <= '0;
    end else begin
      latch_q    <= latch_d;
      decay_q    <= decay_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef SID_POT_EN
  pot_state_e state_q;
  logic [8:0] phase_q;
  logic       pot_dis_q;
  logic       phase_end, tick_dis, tick_chg;

  assign phase_end = (phase_q == 9'(POT_PHASE_TICKS - 1));
  assign tick_dis  = ce_1m & (state_q == DISCHARGE);
  assign tick_chg  = ce_1m & (state_q == CHARGE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DISCHARGE;
      phase_q   <= '0;
      pot_dis_q <= 1'b1;
    end else if (ce_1m) begin
      if (phase_end) begin
        phase_q <= '0;
        if (state_q == DISCHARGE) begin
          state_q   <= CHARGE;
          pot_dis_q <= 1'b0;
        end else begin
          state_q   <= DISCHARGE;
          pot_dis_q <= 1'b1;
        end
      end else begin
        phase_q <= phase_q + 9'd1;
      end
    end
  end

  assign pot_dis = pot_dis_q;

  sid_pot_axis u_pot_x (
    .clock_i  (clock),
    .reset_ni (reset_n),
    .clr_i    (tick_dis),
    .cnt_en_i (tick_chg),
    .latch_i  (phase_end),
    .comp_i   (pot_x_in),
    .result_o (potx_val)
  );

  sid_pot_axis u_pot_y (
    .clock_i  (clock),
    .reset_ni (reset_n),
    .clr_i    (tick_dis),
    .cnt_en_i (tick_chg),
    .latch_i  (phase_end),
    .comp_i   (pot_y_in),
    .result_o (poty_val)
  );
`else
  logic unused_pot;
  assign unused_pot = pot_x_in ^ pot_y_in;
  assign potx_val   = 8'hFF;
  assign poty_val   = 8'hFF;
  assign pot_dis    = 1'b0;
`endif

endmodule

// File: tb/tb_sid_regs.sv
// Directed self-checking bench for sid_regs (decay shortened to 10 ticks).
// Covers write mapping, read-back timing/hold, decay and reload, and the
// pot sampler or its tied-off values depending on SID_POT_EN.
module tb_sid_regs;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ce_1m, cs, we;
  logic [4:0]   addr;
  logic [7:0]   data_in, data_out;
  logic [167:0] voice_regs;
  logic [2:0]   fc_lo;
  logic [7:0]   fc_hi, res_filt, mode_vol;
  logic [7:0]   osc3_in, env3_in;
  logic         pot_x_in, pot_y_in, pot_dis;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sid_regs #(.DECAY_CYCLES(10), .DECAY_W(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce_1m      (ce_1m),
    .cs         (cs),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .voice_regs (voice_regs),
    .fc_lo      (fc_lo),
    .fc_hi      (fc_hi),
    .res_filt   (res_filt),
    .mode_vol   (mode_vol),
    .osc3_in    (osc3_in),
    .env3_in    (env3_in),
    .pot_x_in   (pot_x_in),
    .pot_y_in   (pot_y_in),
    .pot_dis    (pot_dis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drives happen at the falling edge; the DUT samples on the next rise.
  task automatic bus_wr(input logic [4:0] a, input logic [7:0] d, input logic with_tick);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d; ce_1m = with_tick;
    @(negedge clock);
    cs = 1'b0; we = 1'b0; ce_1m = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clock);
    cs = 1'b0;
    d = data_out;
  endtask

  task automatic tick();
    ce_1m = 1'b1;
    @(negedge clock);
    ce_1m = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rv;
    int         dis_cnt;

    reset_n = 1'b0; ce_1m = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    osc3_in = '0; env3_in = '0; pot_x_in = 1'b0; pot_y_in = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_voice_any", 32'(|voice_regs), 32'h0);
    chk("rst_mode_vol", 32'(mode_vol), 32'h00);
`ifdef SID_POT_EN
    chk("rst_pot_dis", 32'(pot_dis), 32'h1);
`else
    chk("rst_pot_dis", 32'(pot_dis), 32'h0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    // Voice register writes.
    bus_wr(5'h12, 8'h01, 1'b0);
    bus_wr(5'h00, 8'h34, 1'b0);
    bus_wr(5'h01, 8'h12, 1'b0);
    chk("v1_freq_lo", 32'(voice_regs[7:0]), 32'h34);
    chk("v1_freq_hi", 32'(voice_regs[15:8]), 32'h12);
    chk("v3_freq_lo", 32'(voice_regs[119:112]), 32'h00);
    chk("v3_control", 32'(voice_regs[151:144]), 32'h01);
    bus_wr(5'h03, 8'hAB, 1'b0);
    chk("v1_pw_hi", 32'(voice_regs[31:24]), 32'h0B);

    // Filter / volume.
    bus_wr(5'h15, 8'hFF, 1'b0);
    bus_wr(5'h16, 8'h5C, 1'b0);
    bus_wr(5'h17, 8'hA1, 1'b0);
    bus_wr(5'h18, 8'h1F, 1'b0);
    chk("fc_lo", 32'(fc_lo), 32'h7);
    chk("fc_hi", 32'(fc_hi), 32'h5C);
    chk("res_filt", 32'(res_filt), 32'hA1);

    // Unmapped write is not stored but lands on the open bus.
    bus_wr(5'h1D, 8'h77, 1'b0);
    chk("unmapped_no_store", 32'(mode_vol), 32'h1F);
    bus_rd(5'h00, rv);
    chk("rd_latch", 32'(rv), 32'h77);

    // Live read-only registers.
    osc3_in = 8'h5A;
    bus_rd(5'h1B, rv);
    chk("rd_osc3", 32'(rv), 32'h5A);
    env3_in = 8'hC3;
    bus_rd(5'h1C, rv);
    chk("rd_env3", 32'(rv), 32'hC3);
    env3_in = 8'h00; osc3_in = 8'h00;
    repeat (2) @(negedge clock);
    chk("rd_hold", 32'(data_out), 32'hC3);

    // Decay: alive after 9 ticks, gone after 11.
    bus_wr(5'h1D, 8'h66, 1'b0);
    repeat (9) tick();
    bus_rd(5'h05, rv);
    chk("decay_before", 32'(rv), 32'h66);
    repeat (2) tick();
    bus_rd(5'h05, rv);
    chk("decay_after", 32'(rv), 32'h00);

    // Write coinciding with the final decay tick reloads the full count.
    bus_wr(5'h1E, 8'h42, 1'b0);
    repeat (9) tick();
    bus_wr(5'h1F, 8'h99, 1'b1);
    bus_rd(5'h00, rv);
    chk("reload_value", 32'(rv), 32'h99);
    repeat (9) tick();
    bus_rd(5'h00, rv);
    chk("reload_9", 32'(rv), 32'h99);
    tick();
    bus_rd(5'h00, rv);
    chk("reload_10", 32'(rv), 32'h00);

`ifdef SID_POT_EN
    // Restart the sampler from a known phase.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    dis_cnt = 0;
    for (int t = 0; t < 512; t++) begin
      if (t == 356) pot_x_in = 1'b1;
      dis_cnt += int'(pot_dis);
      tick();
    end
    pot_x_in = 1'b0;
    chk("pot_dis_ticks", 32'(dis_cnt), 32'd256);
    bus_rd(5'h19, rv);
    chk("potx_near_100", 32'(rv >= 8'd98 && rv <= 8'd102), 32'h1);
    bus_rd(5'h1A, rv);
    chk("poty_sat", 32'(rv), 32'hFF);

    // Reset mid-charge.
    for (int t = 0; t < 300; t++) tick();
    chk("dis_in_charge", 32'(pot_dis), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("dis_async_rst", 32'(pot_dis), 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    bus_rd(5'h19, rv);
    chk("potx_after_rst", 32'(rv), 32'h00);
    bus_rd(5'h1A, rv);
    chk("poty_after_rst", 32'(rv), 32'h00);

    for (int t = 0; t < 512; t++) begin
      if (t == 306) pot_y_in = 1'b1;
      tick();
    end
    pot_y_in = 1'b0;
    bus_rd(5'h1A, rv);
    chk("poty_near_50", 32'(rv >= 8'd48 && rv <= 8'd52), 32'h1);
    bus_rd(5'h19, rv);
    chk("potx_sat", 32'(rv), 32'hFF);
`else
    bus_rd(5'h19, rv);
    chk("potx_off", 32'(rv), 32'hFF);
    bus_rd(5'h1A, rv);
    chk("poty_off", 32'(rv), 32'hFF);
    chk("pot_dis_off", 32'(pot_dis), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
